stage_if: RTL and testbench



---
 rtl/stage_if_pkg.sv | 32 +++
 rtl/if_fetch_buf.sv | 30 +++
 rtl/stage_if.sv | 101 ++++++++++
 tb/tb_stage_if.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/stage_if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package stage_if_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned IF2ID_W = 2 * XLEN;

  localparam logic [XLEN-1:0] RESET_PC_DEF  = XLEN'(32'h0000_0000);
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = XLEN'(32'h0000_0000);
  localparam logic [XLEN-1:0] PC_STEP       = XLEN'(4);
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = XLEN'(32'hFFFF_FFFC);

  typedef enum logic [1:0] {
    S_RESET   = 2'd0,
    S_FETCH   = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] instr;
  } if2id_t;

  // Bubble payload: keeps the supplied next_pc and carries the NOP encoding.
  function automatic if2id_t bubble(input logic [XLEN-1:0] npc, input logic [XLEN-1:0] nop);
    if2id_t b;
    b.next_pc = npc;
    b.instr   = nop;
    return b;
  endfunction

endpackage

// File: rtl/if_fetch_buf.sv
// One-entry holding register for a word fetched while stage_id is stalled.
module if_fetch_buf
  import stage_if_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   clear,
  input  logic   drain,
  input  if2id_t din,
  output logic   valid,
  output if2id_t dout
);

  // A redirect beats a same-cycle load: the buffered word would be stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stage_if.sv
// Instruction fetch stage: PC, req/ack memory handshake, redirect handling and
// the registered {next_pc, instr} payload towards stage_id.
module stage_if
  import stage_if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_dest,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output if2id_t          interstage_if2id
);

  state_t          state;
  logic [XLEN-1:0] pc;
  if2id_t          out_q;

  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] dest_aligned;
  logic            buf_load;
  logic            buf_clear;
  logic            buf_drain;
  logic            buf_valid;
  if2id_t          buf_dout;
  if2id_t          fetched;

  assign pc_inc           = pc + PC_STEP;
  assign dest_aligned     = branch_dest & PC_ALIGN_MASK;
  assign fetched          = '{next_pc: pc_inc, instr: mem_rdata};
  assign mem_req          = (state == S_FETCH) || (state == S_DISCARD);
  assign mem_addr         = pc;
  assign interstage_if2id = out_q;

  assign buf_load  = (state == S_FETCH) && mem_ack && !branch_taken && stall;
  assign buf_clear = branch_taken;
  assign buf_drain = (state == S_HOLD) && !branch_taken && !stall;

  if_fetch_buf u_fetch_buf (
    .clk   (clk),
    .rst   (rst),
    .load  (buf_load),
    .clear (buf_clear),
    .drain (buf_drain),
    .din   (fetched),
    .valid (buf_valid),
    .dout  (buf_dout)
  );

  // Fetch FSM; priority per edge is rst > branch_taken > mem_ack > idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RESET;
      pc    <= RESET_PC;
      out_q <= bubble('0, NOP_INSTR);
    end else if (branch_taken) begin
      // The delay-slot word already in out_q is kept; only a free slot gets a bubble.
      pc <= dest_aligned;
      if (!stall) out_q <= bubble(dest_aligned, NOP_INSTR);
      unique case (state)
        S_RESET:   state <= S_FETCH;
        S_FETCH:   state <= mem_ack ? S_FETCH : S_DISCARD;
        S_HOLD:    state <= S_FETCH;
        S_DISCARD: state <= S_DISCARD;
        default:   state <= S_RESET;
      endcase
    end else begin
      unique case (state)
        S_RESET: state <= S_FETCH;
        S_FETCH: begin
          if (mem_ack) begin
            pc <= pc_inc;
            if (!stall) out_q <= fetched;
            else        state <= S_HOLD;
          end else if (!stall) begin
            out_q <= bubble(out_q.next_pc, NOP_INSTR);
          end
        end
        S_HOLD: begin
          if (!stall) begin
            out_q <= buf_valid ? buf_dout : bubble(out_q.next_pc, NOP_INSTR);
            state <= S_FETCH;
          end
        end
        S_DISCARD: begin
          // The in-flight word belongs to the old path; drop it and refetch at pc.
          if (mem_ack) state <= S_FETCH;
          if (!stall)  out_q <= bubble(out_q.next_pc, NOP_INSTR);
        end
        default: state <= S_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_if.sv
// Directed self-checking bench for the instruction fetch stage.
module tb_stage_if;
  import stage_if_pkg::*;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_dest;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  if2id_t      if2id;

  int total;
  int bad;

  stage_if #(.RESET_PC(32'h0), .NOP_INSTR(32'h0)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_dest      (branch_dest),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_ack          (mem_ack),
    .mem_rdata        (mem_rdata),
    .interstage_if2id (if2id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0b exp=0", mem_req); end
    total++; if (if2id !== 64'h0) begin bad++; $display("FAIL reset_out got=%h exp=%h", if2id, 64'h0); end
    rst = 1'b0;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL first_cycle_req got=%0b exp=0", mem_req); end
    tick();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin bad++; $display("FAIL first_req got=%0b/%h exp=1/0", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h2408_0005; tick(); mem_ack = 1'b0;
    total++; if (if2id !== {32'h4, 32'h2408_0005}) begin bad++; $display("FAIL first_word got=%h exp=%h", if2id, {32'h4, 32'h2408_0005}); end
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin bad++; $display("FAIL second_req got=%0b/%h exp=1/4", mem_req, mem_addr); end
  endtask

  task automatic test_slow_mem();
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (if2id !== {32'h4, 32'h0}) begin bad++; $display("FAIL slow_bubble%0d got=%h exp=%h", i, if2id, {32'h4, 32'h0}); end
    end
    mem_ack = 1'b1; mem_rdata = 32'h2009_0007; tick(); mem_ack = 1'b0;
    total++; if (if2id !== {32'h8, 32'h2009_0007}) begin bad++; $display("FAIL slow_word got=%h exp=%h", if2id, {32'h8, 32'h2009_0007}); end
    total++; if (mem_addr !== 32'h8) begin bad++; $display("FAIL slow_addr got=%h exp=8", mem_addr); end
  endtask

  task automatic test_stall_on_ack();
    stall = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h8C09_0000; tick(); mem_ack = 1'b0;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL hold_req got=%0b exp=0", mem_req); end
    total++; if (if2id !== {32'h8, 32'h2009_0007}) begin bad++; $display("FAIL hold_out got=%h exp=%h", if2id, {32'h8, 32'h2009_0007}); end
    tick();
    total++; if (mem_req !== 1'b0 || if2id !== {32'h8, 32'h2009_0007}) begin bad++; $display("FAIL hold_keep got=%0b/%h", mem_req, if2id); end
    stall = 1'b0; tick();
    total++; if (if2id !== {32'hC, 32'h8C09_0000}) begin bad++; $display("FAIL drain_out got=%h exp=%h", if2id, {32'hC, 32'h8C09_0000}); end
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'hC) begin bad++; $display("FAIL drain_req got=%0b/%h exp=1/c", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111; tick(); mem_ack = 1'b0;
    total++; if (if2id !== {32'h10, 32'h1111_1111} || mem_addr !== 32'h10) begin bad++; $display("FAIL word_c got=%h/%h", if2id, mem_addr); end
  endtask

  task automatic test_redirect_inflight();
    branch_taken = 1'b1; branch_dest = 32'h103; tick(); branch_taken = 1'b0;
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin bad++; $display("FAIL redir_addr got=%0b/%h exp=1/100", mem_req, mem_addr); end
    total++; if (if2id !== {32'h100, 32'h0}) begin bad++; $display("FAIL redir_bubble got=%h exp=%h", if2id, {32'h100, 32'h0}); end
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; tick(); mem_ack = 1'b0;
    total++; if (if2id.instr !== 32'h0 || mem_req !== 1'b1 || mem_addr !== 32'h100) begin bad++; $display("FAIL stale_drop got=%h/%0b/%h", if2id, mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h2222_0002; tick(); mem_ack = 1'b0;
    total++; if (if2id !== {32'h104, 32'h2222_0002}) begin bad++; $display("FAIL redir_word got=%h exp=%h", if2id, {32'h104, 32'h2222_0002}); end
  endtask

  task automatic test_redirect_with_ack();
    branch_taken = 1'b1; branch_dest = 32'h200; mem_ack = 1'b1; mem_rdata = 32'hBAD0_0001; tick();
    branch_taken = 1'b0; mem_ack = 1'b0;
    total++; if (if2id !== {32'h200, 32'h0}) begin bad++; $display("FAIL coinc_out got=%h exp=%h", if2id, {32'h200, 32'h0}); end
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin bad++; $display("FAIL coinc_req got=%0b/%h exp=1/200", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h3333_0003; tick(); mem_ack = 1'b0;
    total++; if (if2id !== {32'h204, 32'h3333_0003}) begin bad++; $display("FAIL coinc_word got=%h exp=%h", if2id, {32'h204, 32'h3333_0003}); end
  endtask

  task automatic test_redirect_in_hold();
    stall = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hBAD0_0002; tick(); mem_ack = 1'b0;
    branch_taken = 1'b1; branch_dest = 32'h300; tick(); branch_taken = 1'b0;
    total++; if (if2id !== {32'h204, 32'h3333_0003}) begin bad++; $display("FAIL delay_slot got=%h exp=%h", if2id, {32'h204, 32'h3333_0003}); end
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin bad++; $display("FAIL hold_redir_req got=%0b/%h exp=1/300", mem_req, mem_addr); end
    stall = 1'b0; tick();
    total++; if (if2id !== {32'h204, 32'h0}) begin bad++; $display("FAIL no_buf_emit got=%h exp=%h", if2id, {32'h204, 32'h0}); end
    mem_ack = 1'b1; mem_rdata = 32'h4444_0004; tick(); mem_ack = 1'b0;
    total++; if (if2id !== {32'h304, 32'h4444_0004}) begin bad++; $display("FAIL hold_redir_word got=%h exp=%h", if2id, {32'h304, 32'h4444_0004}); end
  endtask

  task automatic test_reset_mid();
    stall = 1'b1; branch_taken = 1'b1; branch_dest = 32'h400; tick(); branch_taken = 1'b0;
    total++; if (if2id !== {32'h304, 32'h4444_0004} || mem_addr !== 32'h400) begin bad++; $display("FAIL discard_stall got=%h/%h", if2id, mem_addr); end
    rst = 1'b1; tick();
    total++; if (if2id !== 64'h0 || mem_req !== 1'b0 || mem_addr !== 32'h0) begin bad++; $display("FAIL mid_reset got=%h/%0b/%h exp=0/0/0", if2id, mem_req, mem_addr); end
    rst = 1'b0; stall = 1'b0;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL mid_reset_gap got=%0b exp=0", mem_req); end
    tick();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin bad++; $display("FAIL restart_req got=%0b/%h exp=1/0", mem_req, mem_addr); end
  endtask

  task automatic test_wrap_back_to_back();
    logic [31:0] words [3];
    words[0] = 32'h5555_0005; words[1] = 32'h6666_0006; words[2] = 32'h7777_0007;
    branch_taken = 1'b1; branch_dest = 32'hFFFF_FFFF; tick(); branch_taken = 1'b0;
    total++; if (mem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_align got=%h exp=fffffffc", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_0000; tick();
    mem_rdata = 32'h1234_5678; tick();
    total++; if (if2id !== {32'h0, 32'h1234_5678} || mem_addr !== 32'h0) begin bad++; $display("FAIL wrap_word got=%h/%h", if2id, mem_addr); end
    for (int i = 0; i < 3; i++) begin
      mem_rdata = words[i]; tick();
      total++;
      if (if2id !== {32'(4 * (i + 1)), words[i]} || mem_req !== 1'b1 || mem_addr !== 32'(4 * (i + 1))) begin
        bad++; $display("FAIL b2b%0d got=%h/%0b/%h exp=%h", i, if2id, mem_req, mem_addr, {32'(4 * (i + 1)), words[i]});
      end
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_dest = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    test_reset();
    test_slow_mem();
    test_stall_on_ack();
    test_redirect_inflight();
    test_redirect_with_ack();
    test_redirect_in_hold();
    test_reset_mid();
    test_wrap_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
